// File: rtl/rst_sequencer.sv
// Staged reset sequencer: holds all domain resets, releases them in index order,
// then raises ready. Optional watchdog trigger enabled by RST_SEQUENCER_WDT_EN.
module rst_sequencer #(
    parameter int STAGES       = 3,
    parameter int HOLD_CYCLES  = 4,
    parameter int STAGE_CYCLES = 2,
    parameter int WDT_CYCLES   = 1000,
    parameter int CNT_W        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst_req,
    input  logic              wdt_kick,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic [1:0]        cause
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [STAGES-1:0] rst_out_reg, rst_out_next;
    logic              ready_reg, ready_next;
    logic [1:0]        cause_reg, cause_next;
    logic [STAGES-1:0] rst_shift;
    logic              wdt_expire;

`ifdef RST_SEQUENCER_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);
    logic [CNT_W-1:0]  wdt_cnt_reg, wdt_cnt_next;
`else
    logic              unused_wdt_kick;
    logic [CNT_W-1:0]  unused_wdt_cycles;
    assign unused_wdt_kick   = wdt_kick;
    assign unused_wdt_cycles = CNT_W'(WDT_CYCLES);
`endif

    // Releasing a stage shifts a zero in from bit 0, so bits drop in index order.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_shift
            if (gi == 0) begin : g_first
                assign rst_shift[gi] = 1'b0;
            end else begin : g_rest
                assign rst_shift[gi] = rst_out_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rst_out_next = rst_out_reg;
        ready_next   = ready_reg;
        cause_next   = cause_reg;
        wdt_expire   = 1'b0;
`ifdef RST_SEQUENCER_WDT_EN
        wdt_cnt_next = '0;
`endif
        case (state_reg)
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next   = ST_RELEASE;
                    cnt_next     = '0;
                    rst_out_next = rst_shift;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_reg == STAGE_LAST) begin
                    cnt_next = '0;
                    // All stages already released: this interval ends in ready.
                    if (rst_out_reg == '0) begin
                        state_next = ST_RUN;
                        ready_next = 1'b1;
                    end else begin
                        rst_out_next = rst_shift;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
`ifdef RST_SEQUENCER_WDT_EN
                if (wdt_kick) begin
                    wdt_cnt_next = '0;
                end else if (wdt_cnt_reg == WDT_LAST) begin
                    wdt_expire = 1'b1;
                end else begin
                    wdt_cnt_next = wdt_cnt_reg + 1'b1;
                end
`endif
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase

        // Software request outranks watchdog expiry when reporting the cause.
        if (sw_rst_req || wdt_expire) begin
            state_next   = ST_HOLD;
            cnt_next     = '0;
            rst_out_next = '1;
            ready_next   = 1'b0;
            cause_next   = sw_rst_req ? 2'd1 : 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_HOLD;
            cnt_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
            cause_reg   <= 2'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rst_out_reg <= rst_out_next;
            ready_reg   <= ready_next;
            cause_reg   <= cause_next;
        end
    end

`ifdef RST_SEQUENCER_WDT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_reg <= '0;
        end else begin
            wdt_cnt_reg <= wdt_cnt_next;
        end
    end
`endif

    assign rst_out = rst_out_reg;
    assign ready   = ready_reg;
    assign cause   = cause_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: release timing, software triggers, reset
// priority and, when RST_SEQUENCER_WDT_EN is defined, watchdog behaviour.
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       wdt_kick = 1'b0;
    logic [2:0] rst_out;
    logic       ready;
    logic [1:0] cause;

    int checks = 0;
    int failures = 0;

    // Expected outputs after edges 0..9 following a trigger (defaults H=4, S=2).
    logic [2:0] exp_ro  [0:9] = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b110,
                                  3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
    logic       exp_rdy [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_sequencer #(
        .STAGES(3), .HOLD_CYCLES(4), .STAGE_CYCLES(2), .WDT_CYCLES(8), .CNT_W(10)
    ) dut (
        .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick),
        .rst_out(rst_out), .ready(ready), .cause(cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called one negedge after the trigger edge; walks edges 0..9 and ends in RUN.
    task automatic run_seq(input string tag, input logic [1:0] exp_cause);
        check({tag, " trig rst_out"}, 32'(rst_out), 32'b111);
        check({tag, " trig ready"}, 32'(ready), 32'd0);
        check({tag, " trig cause"}, 32'(cause), 32'(exp_cause));
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            check($sformatf("%s e%0d rst_out", tag, e), 32'(rst_out), 32'(exp_ro[e]));
            check($sformatf("%s e%0d ready", tag, e), 32'(ready), 32'(exp_rdy[e]));
        end
        check({tag, " end cause"}, 32'(cause), 32'(exp_cause));
        $display("seq %s: rst_out=%b ready=%0d cause=%0d", tag, rst_out, ready, cause);
    endtask

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
    endtask

    initial begin
        // Power-on reset held three cycles.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_seq("por", 2'd0);

        // Software request from RUN.
        pulse_sw();
        run_seq("sw_run", 2'd1);

        // Software request mid-release while rst_out = 100.
        pulse_sw();
        repeat (6) @(negedge clk);
        check("mid_release rst_out", 32'(rst_out), 32'b100);
        pulse_sw();
        run_seq("sw_release", 2'd1);

        // Request held high keeps the block in HOLD.
        sw_rst_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("sw_held c%0d rst_out", i), 32'(rst_out), 32'b111);
        end
        sw_rst_req = 1'b0;
        run_seq("sw_held", 2'd1);

        // External reset wins over a simultaneous software request.
        rst = 1'b1;
        sw_rst_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sw_rst_req = 1'b0;
        run_seq("rst_prio", 2'd0);

`ifdef RST_SEQUENCER_WDT_EN
        // No kicks: the 8th RUN edge expires the watchdog.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("wdt_idle c%0d ready", i), 32'(ready), 32'd1);
        end
        @(negedge clk);
        run_seq("wdt_expire", 2'd2);

        // Regular kicks keep the block in RUN.
        for (int i = 0; i < 100; i++) begin
            wdt_kick = (i % 5 == 4);
            @(negedge clk);
            check($sformatf("wdt_kicked c%0d ready", i), 32'(ready), 32'd1);
        end
        wdt_kick = 1'b0;
        $display("seq wdt_kicked: ready=%0d cause=%0d", ready, cause);

        // Kick landing on the expiry edge cancels the reset.
        pulse_sw();
        run_seq("wdt_pre", 2'd1);
        repeat (7) @(negedge clk);
        wdt_kick = 1'b1;
        @(negedge clk);
        wdt_kick = 1'b0;
        check("wdt_coincident ready", 32'(ready), 32'd1);
        check("wdt_coincident cause", 32'(cause), 32'd1);
        repeat (7) @(negedge clk);
        check("wdt_after_kick ready", 32'(ready), 32'd1);
        $display("seq wdt_coincident: ready=%0d cause=%0d", ready, cause);
`else
        // Without the watchdog, RUN persists and wdt_kick has no effect.
        for (int i = 0; i < 40; i++) begin
            wdt_kick = (i % 7 == 3);
            @(negedge clk);
            check($sformatf("no_wdt c%0d ready", i), 32'(ready), 32'd1);
        end
        wdt_kick = 1'b0;
        check("no_wdt rst_out", 32'(rst_out), 32'd0);
        check("no_wdt cause", 32'(cause), 32'd0);
        $display("seq no_wdt: ready=%0d cause=%0d", ready, cause);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
